// File: rtl/ex_stage_if.sv
// ID/EX, writeback and EX/MEM signal bundle for the execute stage.
// The slave side is the execute stage itself; the master side is whatever
// drives the ID/EX register and consumes EX/MEM.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] ID_EX_PC;
    logic [XLEN-1:0] ID_EX_RD1;
    logic [XLEN-1:0] ID_EX_RD2;
    logic [XLEN-1:0] ID_EX_Imm;
    logic [31:0]     ID_EX_Instr;
    logic [1:0]      ID_EX_ASel;
    logic [1:0]      ID_EX_BSel;
    logic [3:0]      ID_EX_ALUSel;
    logic            ID_EX_MemR;
    logic            ID_EX_MemW;
    logic [1:0]      ID_EX_WBSel;
    logic            ID_EX_RegWEn;

    logic [4:0]      WB_rd;
    logic [XLEN-1:0] WB_data;
    logic            WB_RegWEn;

    logic            stall;
    logic            flush;

    logic [XLEN-1:0] EX_MEM_ALU;
    logic [XLEN-1:0] EX_MEM_RD2;
    logic [XLEN-1:0] EX_MEM_PC4;
    logic [31:0]     EX_MEM_Instr;
    logic            EX_MEM_MemR;
    logic            EX_MEM_MemW;
    logic            EX_MEM_RegWEn;
    logic [1:0]      EX_MEM_WBSel;

    modport master (
        output ID_EX_PC, ID_EX_RD1, ID_EX_RD2, ID_EX_Imm, ID_EX_Instr,
               ID_EX_ASel, ID_EX_BSel, ID_EX_ALUSel, ID_EX_MemR, ID_EX_MemW,
               ID_EX_WBSel, ID_EX_RegWEn, WB_rd, WB_data, WB_RegWEn, stall, flush,
        input  EX_MEM_ALU, EX_MEM_RD2, EX_MEM_PC4, EX_MEM_Instr, EX_MEM_MemR,
               EX_MEM_MemW, EX_MEM_RegWEn, EX_MEM_WBSel
    );

    modport slave (
        input  ID_EX_PC, ID_EX_RD1, ID_EX_RD2, ID_EX_Imm, ID_EX_Instr,
               ID_EX_ASel, ID_EX_BSel, ID_EX_ALUSel, ID_EX_MemR, ID_EX_MemW,
               ID_EX_WBSel, ID_EX_RegWEn, WB_rd, WB_data, WB_RegWEn, stall, flush,
        output EX_MEM_ALU, EX_MEM_RD2, EX_MEM_PC4, EX_MEM_Instr, EX_MEM_MemR,
               EX_MEM_MemW, EX_MEM_RegWEn, EX_MEM_WBSel
    );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding from EX/MEM and WB, ALU, and the
// EX/MEM pipeline register with stall (hold) and flush (bubble).
module ex_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    ex_stage_if.slave    bus
);
    logic [XLEN-1:0] r_alu, r_rd2, r_pc4;
    logic [31:0]     r_instr;
    logic            r_memr, r_memw, r_regwen;
    logic [1:0]      r_wbsel;

    logic [4:0]      rs1, rs2, ex_rd;
    logic            ex_fwd_ok, wb_fwd_ok;
    logic [XLEN-1:0] ex_fwd_val;
    logic [XLEN-1:0] fwd1, fwd2, op_a, op_b, alu_y, pc4;
    logic [4:0]      shamt;

    assign rs1   = bus.ID_EX_Instr[19:15];
    assign rs2   = bus.ID_EX_Instr[24:20];
    assign ex_rd = r_instr[11:7];

    // A load's ALU field holds an address, not the loaded data, so it is never a source.
    assign ex_fwd_ok  = r_regwen && !r_memr && (ex_rd != 5'd0);
    assign ex_fwd_val = (r_wbsel == 2'd2) ? r_pc4 : r_alu;
    assign wb_fwd_ok  = bus.WB_RegWEn && (bus.WB_rd != 5'd0);

    // Forwarding muxes: EX/MEM has priority over WB as it is the younger result.
    always_comb begin
        fwd1 = bus.ID_EX_RD1;
        fwd2 = bus.ID_EX_RD2;
        if (ex_fwd_ok && ex_rd == rs1)
            fwd1 = ex_fwd_val;
        else if (wb_fwd_ok && bus.WB_rd == rs1)
            fwd1 = bus.WB_data;
        if (ex_fwd_ok && ex_rd == rs2)
            fwd2 = ex_fwd_val;
        else if (wb_fwd_ok && bus.WB_rd == rs2)
            fwd2 = bus.WB_data;
    end

    // Operand selection for the ALU.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (bus.ID_EX_ASel)
            2'd0:    op_a = fwd1;
            2'd1:    op_a = bus.ID_EX_PC;
            default: op_a = '0;
        endcase
        case (bus.ID_EX_BSel)
            2'd0:    op_b = fwd2;
            2'd1:    op_b = bus.ID_EX_Imm;
            2'd2:    op_b = XLEN'(4);
            default: op_b = '0;
        endcase
    end

    assign shamt = op_b[4:0];
    assign pc4   = bus.ID_EX_PC + XLEN'(4);

    // ALU; unassigned opcodes produce zero.
    always_comb begin
        alu_y = '0;
        case (bus.ID_EX_ALUSel)
            4'd0:    alu_y = op_a + op_b;
            4'd1:    alu_y = op_a - op_b;
            4'd2:    alu_y = op_a << shamt;
            4'd3:    alu_y = XLEN'($signed(op_a) < $signed(op_b));
            4'd4:    alu_y = XLEN'(op_a < op_b);
            4'd5:    alu_y = op_a ^ op_b;
            4'd6:    alu_y = op_a >> shamt;
            4'd7:    alu_y = $signed(op_a) >>> shamt;
            4'd8:    alu_y = op_a | op_b;
            4'd9:    alu_y = op_a & op_b;
            4'd10:   alu_y = op_b;
            default: alu_y = '0;
        endcase
    end

    // EX/MEM register: flush beats stall beats normal load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu    <= '0;
            r_rd2    <= '0;
            r_pc4    <= '0;
            r_instr  <= NOP_INSTR;
            r_memr   <= 1'b0;
            r_memw   <= 1'b0;
            r_regwen <= 1'b0;
            r_wbsel  <= 2'd0;
        end else if (bus.flush) begin
            r_alu    <= '0;
            r_rd2    <= '0;
            r_pc4    <= '0;
            r_instr  <= NOP_INSTR;
            r_memr   <= 1'b0;
            r_memw   <= 1'b0;
            r_regwen <= 1'b0;
            r_wbsel  <= 2'd0;
        end else if (!bus.stall) begin
            r_alu    <= alu_y;
            r_rd2    <= fwd2;
            r_pc4    <= pc4;
            r_instr  <= bus.ID_EX_Instr;
            r_memr   <= bus.ID_EX_MemR;
            r_memw   <= bus.ID_EX_MemW;
            r_regwen <= bus.ID_EX_RegWEn;
            r_wbsel  <= bus.ID_EX_WBSel;
        end
    end

    assign bus.EX_MEM_ALU    = r_alu;
    assign bus.EX_MEM_RD2    = r_rd2;
    assign bus.EX_MEM_PC4    = r_pc4;
    assign bus.EX_MEM_Instr  = r_instr;
    assign bus.EX_MEM_MemR   = r_memr;
    assign bus.EX_MEM_MemW   = r_memw;
    assign bus.EX_MEM_RegWEn = r_regwen;
    assign bus.EX_MEM_WBSel  = r_wbsel;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the EX/MEM register.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model of the EX/MEM register contents.
    logic [31:0] m_alu, m_rd2, m_pc4, m_instr;
    logic        m_memr, m_memw, m_regwen;
    logic [1:0]  m_wbsel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("alu",    bus.EX_MEM_ALU,   m_alu);
        chk("rd2",    bus.EX_MEM_RD2,   m_rd2);
        chk("pc4",    bus.EX_MEM_PC4,   m_pc4);
        chk("instr",  bus.EX_MEM_Instr, m_instr);
        chk("memr",   32'(bus.EX_MEM_MemR),   32'(m_memr));
        chk("memw",   32'(bus.EX_MEM_MemW),   32'(m_memw));
        chk("regwen", 32'(bus.EX_MEM_RegWEn), 32'(m_regwen));
        chk("wbsel",  32'(bus.EX_MEM_WBSel),  32'(m_wbsel));
    endtask

    task automatic model_bubble();
        m_alu = 0; m_rd2 = 0; m_pc4 = 0; m_instr = 32'h13;
        m_memr = 0; m_memw = 0; m_regwen = 0; m_wbsel = 0;
    endtask

    // Value a source register should read given the model's in-flight results.
    function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] id_val);
        if (rs == 0) return id_val;
        if (m_regwen && !m_memr && m_instr[11:7] == rs)
            return (m_wbsel == 2) ? m_pc4 : m_alu;
        if (bus.WB_RegWEn && bus.WB_rd == rs) return bus.WB_data;
        return id_val;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        longint sa, sb;
        sh = b % 32;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        case (op)
            0:  return a + b;
            1:  return a + (~b + 1);
            2:  return a << sh;
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 0;
        endcase
    endfunction

    // One clock: predict the register update from current inputs, then check after the edge.
    task automatic cycle();
        logic [31:0] f1, f2, a, b;
        f1 = src_val(bus.ID_EX_Instr[19:15], bus.ID_EX_RD1);
        f2 = src_val(bus.ID_EX_Instr[24:20], bus.ID_EX_RD2);
        a = (bus.ID_EX_ASel == 0) ? f1 : (bus.ID_EX_ASel == 1) ? bus.ID_EX_PC : 32'd0;
        case (bus.ID_EX_BSel)
            0: b = f2;
            1: b = bus.ID_EX_Imm;
            2: b = 4;
            default: b = 0;
        endcase
        if (bus.flush) begin
            model_bubble();
        end else if (!bus.stall) begin
            m_alu    = alu_ref(bus.ID_EX_ALUSel, a, b);
            m_rd2    = f2;
            m_pc4    = bus.ID_EX_PC + 4;
            m_instr  = bus.ID_EX_Instr;
            m_memr   = bus.ID_EX_MemR;
            m_memw   = bus.ID_EX_MemW;
            m_regwen = bus.ID_EX_RegWEn;
            m_wbsel  = bus.ID_EX_WBSel;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [1:0] asel, input logic [1:0] bsel, input logic [3:0] alusel,
                          input logic [1:0] wbsel, input logic regwen, input logic memr,
                          input logic memw);
        bus.ID_EX_Instr  = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
        bus.ID_EX_ASel   = asel;
        bus.ID_EX_BSel   = bsel;
        bus.ID_EX_ALUSel = alusel;
        bus.ID_EX_WBSel  = wbsel;
        bus.ID_EX_RegWEn = regwen;
        bus.ID_EX_MemR   = memr;
        bus.ID_EX_MemW   = memw;
    endtask

    task automatic set_data(input logic [31:0] pc, input logic [31:0] rd1,
                            input logic [31:0] rd2, input logic [31:0] imm);
        bus.ID_EX_PC  = pc;
        bus.ID_EX_RD1 = rd1;
        bus.ID_EX_RD2 = rd2;
        bus.ID_EX_Imm = imm;
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic [31:0] data, input logic en);
        bus.WB_rd     = rd;
        bus.WB_data   = data;
        bus.WB_RegWEn = en;
    endtask

    // Directed scenarios, mid-run reset, then random traffic.
    initial begin
        rst = 1'b1;
        bus.stall = 0;
        bus.flush = 0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_data(0, 0, 0, 0);
        set_wb(0, 0, 0);
        #2 rst = 1'b0;
        #1;
        model_bubble();
        check_all();
        chk("reset_instr", bus.EX_MEM_Instr, 32'h13);

        // addi x1,x0,5 ; add x2,x1,x1 with stale ID values
        set_op(1, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        set_data(32'h100, 0, 0, 5);
        cycle();
        set_op(2, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        set_data(32'h104, 0, 0, 0);
        cycle();
        chk("fwd_exmem", bus.EX_MEM_ALU, 32'd10);
        chk("fwd_rd2",   bus.EX_MEM_RD2, 32'd5);

        // WB forwarding, then EX/MEM overriding WB for the same register
        set_wb(3, 7, 1);
        set_op(4, 3, 0, 0, 0, 1, 1, 1, 0, 0);
        set_data(32'h108, 32'h55, 0, 0);
        cycle();
        chk("fwd_wb", bus.EX_MEM_ALU, 32'd7);
        set_op(3, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        set_data(32'h10C, 0, 0, 9);
        cycle();
        set_op(5, 3, 0, 0, 0, 1, 1, 1, 0, 0);
        set_data(32'h110, 32'h55, 0, 0);
        cycle();
        chk("fwd_prio", bus.EX_MEM_ALU, 32'd9);

        // x0 is never forwarded
        set_wb(0, 32'hFF, 1);
        set_op(6, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        set_data(32'h114, 32'h11, 32'h22, 0);
        cycle();
        chk("x0_nofwd", bus.EX_MEM_ALU, 32'h33);

        // stall for three cycles with changing inputs, then stall+flush
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_op(5'($urandom_range(1, 31)), 6, 5, 0, 0, 4'(i), 1, 1, 0, 1);
            set_data($urandom, $urandom, $urandom, $urandom);
            set_wb(6, $urandom, 1);
            cycle();
            chk("stall_hold", bus.EX_MEM_ALU, 32'h33);
        end
        // release: forwarding still sees the held x6 result
        bus.stall = 0;
        set_op(7, 6, 0, 0, 0, 0, 1, 1, 0, 0);
        set_data(32'h118, 0, 0, 0);
        cycle();
        chk("fwd_after_stall", bus.EX_MEM_ALU, 32'h33);
        bus.stall = 1;
        bus.flush = 1;
        cycle();
        chk("flush_regwen", 32'(bus.EX_MEM_RegWEn), 32'd0);
        chk("flush_instr",  bus.EX_MEM_Instr, 32'h13);
        bus.stall = 0;
        bus.flush = 0;
        set_wb(0, 0, 0);

        // SRA, SLTU, SLT
        set_op(8, 0, 0, 0, 1, 7, 1, 1, 0, 0);
        set_data(32'h11C, 32'h8000_0000, 0, 4);
        cycle();
        chk("sra", bus.EX_MEM_ALU, 32'hF800_0000);
        set_op(8, 0, 0, 0, 1, 4, 1, 1, 0, 0);
        set_data(32'h120, 1, 0, 32'hFFFF_FFFF);
        cycle();
        chk("sltu", bus.EX_MEM_ALU, 32'd1);
        set_op(8, 0, 0, 0, 1, 3, 1, 1, 0, 0);
        cycle();
        chk("slt", bus.EX_MEM_ALU, 32'd0);

        // load in EX/MEM is not forwarded
        set_op(7, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        set_data(32'h124, 0, 0, 32'h100);
        cycle();
        set_op(9, 7, 0, 0, 0, 0, 1, 1, 0, 0);
        set_data(32'h128, 32'h55, 0, 0);
        cycle();
        chk("load_nofwd", bus.EX_MEM_ALU, 32'h55);

        // PC+4 wrap and forwarding of a link value
        set_op(10, 0, 0, 1, 2, 0, 2, 1, 0, 0);
        set_data(32'hFFFF_FFFC, 0, 0, 0);
        cycle();
        chk("pc4_wrap", bus.EX_MEM_PC4, 32'd0);
        set_op(11, 10, 0, 0, 3, 0, 1, 1, 0, 0);
        set_data(32'h200, 32'h77, 0, 0);
        cycle();
        chk("fwd_link", bus.EX_MEM_ALU, 32'd0);

        // reset in the middle of a cycle discards the in-flight result
        set_op(12, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        set_data(32'h300, 0, 0, 32'h1234);
        cycle();
        #2 rst = 1'b1;
        #1;
        model_bubble();
        check_all();
        rst = 1'b0;

        // random traffic with a small register set to make hazards frequent
        for (int n = 0; n < 400; n++) begin
            set_op(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   2'($urandom), 2'($urandom), 4'($urandom), 2'($urandom_range(0, 2)),
                   1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            set_data(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                     $urandom, $urandom,
                     ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)));
            set_wb(5'($urandom_range(0, 3)), $urandom, 1'($urandom));
            bus.stall = ($urandom_range(0, 5) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
